// File: rtl/alu_ctrl_decode.sv
// Registered MIPS ALU control decoder: op/funct -> 4-bit ALUop plus syscall/jr/shamt/illegal flags.
// Define ALU_CTRL_DECODE_MULDIV_EN to decode mult/multu/div/divu; otherwise those functs are illegal.
module alu_ctrl_decode (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [5:0] op,
    input  logic [5:0] ft,
    output logic       out_valid,
    output logic [3:0] ALUop,
    output logic       IsSyscall,
    output logic       IsJR,
    output logic       IsShamt,
    output logic       IsIllegal
);

    // Valid semantics: in_valid qualifies op/ft in the same cycle and there is no ready;
    // out_valid is in_valid delayed one edge and qualifies every registered output.
    localparam logic [3:0] ALU_SLL  = 4'b0000;
    localparam logic [3:0] ALU_SRA  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0010;
    localparam logic [3:0] ALU_MUL  = 4'b0011;
    localparam logic [3:0] ALU_DIV  = 4'b0100;
    localparam logic [3:0] ALU_ADD  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1100;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       is_syscall;
        logic       is_jr;
        logic       is_shamt;
        logic       is_illegal;
    } decode_t;

    decode_t funct_dec;
    decode_t opcode_dec;
    decode_t dec_d;
    decode_t dec_q;
    logic    valid_d;
    logic    valid_q;

    // R-type funct decoder
    always_comb begin
        funct_dec = '0;
        unique case (ft)
            6'b100000, 6'b100001: funct_dec.alu_op = ALU_ADD;
            6'b100010, 6'b100011: funct_dec.alu_op = ALU_SUB;
            6'b100100:            funct_dec.alu_op = ALU_AND;
            6'b100101:            funct_dec.alu_op = ALU_OR;
            6'b100110:            funct_dec.alu_op = ALU_XOR;
            6'b100111:            funct_dec.alu_op = ALU_NOR;
            6'b101010:            funct_dec.alu_op = ALU_SLT;
            6'b101011:            funct_dec.alu_op = ALU_SLTU;
            6'b000000: begin
                funct_dec.alu_op   = ALU_SLL;
                funct_dec.is_shamt = 1'b1;
            end
            6'b000010: begin
                funct_dec.alu_op   = ALU_SRL;
                funct_dec.is_shamt = 1'b1;
            end
            6'b000011: begin
                funct_dec.alu_op   = ALU_SRA;
                funct_dec.is_shamt = 1'b1;
            end
            6'b000100:            funct_dec.alu_op = ALU_SLL;
            6'b000110:            funct_dec.alu_op = ALU_SRL;
            6'b000111:            funct_dec.alu_op = ALU_SRA;
            6'b001000:            funct_dec.is_jr      = 1'b1;
            6'b001100:            funct_dec.is_syscall = 1'b1;
`ifdef ALU_CTRL_DECODE_MULDIV_EN
            6'b011000, 6'b011001: funct_dec.alu_op = ALU_MUL;
            6'b011010, 6'b011011: funct_dec.alu_op = ALU_DIV;
`endif
            default:              funct_dec.is_illegal = 1'b1;
        endcase
    end

    // I-type / branch / memory opcode decoder; never raises the R-type-only flags
    always_comb begin
        opcode_dec = '0;
        unique case (op)
            6'b001000, 6'b001001,
            6'b100011, 6'b101011: opcode_dec.alu_op = ALU_ADD;
            6'b000100, 6'b000101: opcode_dec.alu_op = ALU_SUB;
            6'b001100:            opcode_dec.alu_op = ALU_AND;
            6'b001101:            opcode_dec.alu_op = ALU_OR;
            6'b001110:            opcode_dec.alu_op = ALU_XOR;
            6'b001010:            opcode_dec.alu_op = ALU_SLT;
            6'b001011:            opcode_dec.alu_op = ALU_SLTU;
            default:              opcode_dec.is_illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_d   = (op == OP_SPECIAL) ? funct_dec : opcode_dec;
        valid_d = in_valid;
    end

    // Decode is captured every edge regardless of in_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            dec_q   <= dec_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign ALUop     = dec_q.alu_op;
    assign IsSyscall = dec_q.is_syscall;
    assign IsJR      = dec_q.is_jr;
    assign IsShamt   = dec_q.is_shamt;
    assign IsIllegal = dec_q.is_illegal;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Self-checking bench for alu_ctrl_decode: directed plan plus random vectors against a table-driven model.
// Honours ALU_CTRL_DECODE_MULDIV_EN the same way the design does.
module tb_alu_ctrl_decode;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] op;
    logic [5:0] ft;
    logic       out_valid;
    logic [3:0] ALUop;
    logic       IsSyscall;
    logic       IsJR;
    logic       IsShamt;
    logic       IsIllegal;

    int n_vec = 0;
    int n_err = 0;

    // Packed view: {out_valid, ALUop, IsSyscall, IsJR, IsShamt, IsIllegal}
    logic [8:0] exp_q[$];

    int f_alu[64];
    int o_alu[64];

    alu_ctrl_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .op        (op),
        .ft        (ft),
        .out_valid (out_valid),
        .ALUop     (ALUop),
        .IsSyscall (IsSyscall),
        .IsJR      (IsJR),
        .IsShamt   (IsShamt),
        .IsIllegal (IsIllegal)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want $finish before 500000");
        $fatal(1);
    end

    function automatic logic [8:0] observed();
        return {out_valid, ALUop, IsSyscall, IsJR, IsShamt, IsIllegal};
    endfunction

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got v=%0b alu=%4b sys/jr/sh/ill=%4b, want v=%0b alu=%4b sys/jr/sh/ill=%4b",
                     tag, got[8], got[7:4], got[3:0], exp[8], exp[7:4], exp[3:0]);
        end
    endtask

    // Reference model: lookup tables of the listed encodings, -1 meaning unsupported
    task automatic build_tables();
        for (int i = 0; i < 64; i++) begin
            f_alu[i] = -1;
            o_alu[i] = -1;
        end
        f_alu[32] = 5;  f_alu[33] = 5;  f_alu[34] = 6;  f_alu[35] = 6;
        f_alu[36] = 7;  f_alu[37] = 8;  f_alu[38] = 9;  f_alu[39] = 10;
        f_alu[42] = 11; f_alu[43] = 12;
        f_alu[0]  = 0;  f_alu[2]  = 2;  f_alu[3]  = 1;
        f_alu[4]  = 0;  f_alu[6]  = 2;  f_alu[7]  = 1;
        f_alu[8]  = 0;  f_alu[12] = 0;
`ifdef ALU_CTRL_DECODE_MULDIV_EN
        f_alu[24] = 3;  f_alu[25] = 3;  f_alu[26] = 4;  f_alu[27] = 4;
`endif
        o_alu[8]  = 5;  o_alu[9]  = 5;  o_alu[35] = 5;  o_alu[43] = 5;
        o_alu[4]  = 6;  o_alu[5]  = 6;
        o_alu[12] = 7;  o_alu[13] = 8;  o_alu[14] = 9;
        o_alu[10] = 11; o_alu[11] = 12;
    endtask

    function automatic logic [8:0] ref_decode(input logic v, input logic [5:0] o, input logic [5:0] f);
        int   a;
        logic sy, jr, sh;
        sy = 1'b0; jr = 1'b0; sh = 1'b0;
        if (o == 6'd0) begin
            a  = f_alu[f];
            sh = (f == 6'd0) || (f == 6'd2) || (f == 6'd3);
            jr = (f == 6'd8);
            sy = (f == 6'd12);
        end else begin
            a = o_alu[o];
        end
        if (a < 0) return {v, 4'b0000, 4'b0001};
        return {v, 4'(a), sy, jr, sh, 1'b0};
    endfunction

    // Driver: present one vector after the edge, check it one edge later
    task automatic apply(input logic v, input logic [5:0] o, input logic [5:0] f, input string tag);
        in_valid = v;
        op       = o;
        ft       = f;
        exp_q.push_back(ref_decode(v, o, f));
        @(posedge clk);
        #1;
        check_eq(tag, observed(), exp_q.pop_front());
    endtask

    logic [5:0] rtype_ft[7];
    logic [5:0] ctl_ft[5];
    logic [5:0] itype_op[6];
    logic [5:0] legal_op[12];

    initial begin
        build_tables();
        rtype_ft = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b101011};
        ctl_ft   = '{6'b000000, 6'b000010, 6'b000011, 6'b001000, 6'b001100};
        itype_op = '{6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001010, 6'b001011};
        legal_op = '{6'b000000, 6'b001000, 6'b001001, 6'b100011, 6'b101011, 6'b000100,
                     6'b000101, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001011};

        // Reset held with addi presented: everything stays 0
        rst_n    = 1'b0;
        in_valid = 1'b1;
        op       = 6'b001000;
        ft       = 6'b000000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_hold", observed(), 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reset_release_addi", observed(), {1'b1, 4'b0101, 4'b0000});

        foreach (rtype_ft[i]) apply(1'b1, 6'd0, rtype_ft[i], $sformatf("rtype_ft%06b", rtype_ft[i]));
        foreach (ctl_ft[i])   apply(1'b1, 6'd0, ctl_ft[i], $sformatf("ctl_ft%06b", ctl_ft[i]));
        foreach (itype_op[i]) apply(1'b1, itype_op[i], 6'b001100, $sformatf("itype_op%06b", itype_op[i]));

        apply(1'b1, 6'b111111, 6'b000000, "illegal_op");
        apply(1'b1, 6'b000000, 6'b111111, "illegal_ft");
        apply(1'b1, 6'b000000, 6'b011010, "muldiv_div");
        apply(1'b1, 6'b000000, 6'b011000, "muldiv_mult");
        apply(1'b0, 6'b001101, 6'b000000, "invalid_captured");

        // Mid-stream reset clears outputs immediately
        apply(1'b1, 6'b001110, 6'b000000, "pre_reset_xori");
        in_valid = 1'b1;
        op       = 6'b001011;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_clear", observed(), 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 6'b001011, 6'b000000, "post_reset_sltiu");

        // Random back-to-back vectors biased toward legal codes
        for (int n = 0; n < 400; n++) begin
            logic [5:0] o, f;
            logic       v;
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       o = 6'd0;
                1, 2:    o = legal_op[$urandom_range(0, 11)];
                default: o = 6'($urandom_range(0, 63));
            endcase
            f = 6'($urandom_range(0, 63));
            apply(v, o, f, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
